// File: rtl/nfc_demod_if.sv
// nfc_demod_if: pulse-record valid/ready bundle
//   pw_data  : pulse length in envelope windows
//   pw_level : modulation level held during that pulse
//   pw_valid : record available (producer)
//   pw_ready : record accepted (consumer)
interface nfc_demod_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] pw_data;
  logic pw_level;
  logic pw_valid;
  logic pw_ready;
  modport master(output pw_data, pw_level, pw_valid, input pw_ready);
  modport slave(input pw_data, pw_level, pw_valid, output pw_ready);
endinterface

// File: rtl/nfc_demod.sv
// nfc_demod: NFC load-modulation envelope detector, hysteresis slicer and pulse-width meter
//   clk, rst        : clock, asynchronous active-high reset
//   v_samp, samp_en : signed coil sample and its strobe
//   thr_hi, thr_lo  : release / assert thresholds on the envelope
//   env_o           : peak magnitude of the last completed window
//   mod_o           : sliced level, 1 = carrier loaded
//   pw              : pulse records {pw_level, pw_data} over valid/ready
//   ovf             : sticky, a record was dropped
// Optional: NFC_DEMOD_GLITCH_FILT_EN requires a new level on two consecutive windows.
module nfc_demod #(
  parameter int WIDTH = 16,
  parameter int WIN = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [WIDTH-1:0] v_samp,
  input  logic samp_en,
  input  logic [WIDTH-2:0] thr_hi,
  input  logic [WIDTH-2:0] thr_lo,
  output logic [WIDTH-2:0] env_o,
  output logic mod_o,
  nfc_demod_if.master pw,
  output logic ovf
);
  localparam int SW = $clog2(WIN);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-2:0] mag, peak, run;
  logic [SW-1:0] scnt;
  logic win_end, env_upd, seen, sl_upd, chg, pend;
  logic tgt, nxt, pend_nxt, push, xfer;
  logic [1:0] step, step_nxt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W:0] add1;
  logic [CNT_W+1:0] adds;
  assign neg = -v_samp;
  // The most-negative code negates to itself; clamp it to full scale.
  assign mag = !v_samp[WIDTH-1] ? v_samp[WIDTH-2:0] : neg[WIDTH-1] ? '1 : neg[WIDTH-2:0];
  assign peak = mag > run ? mag : run;
  assign win_end = samp_en && scnt == SW'(WIN - 1);
  assign tgt = env_o < thr_lo ? 1'b1 : env_o > thr_hi ? 1'b0 : mod_o;
`ifdef NFC_DEMOD_GLITCH_FILT_EN
  // New level is only taken once it repeats; the pending window stays out
  // of the count and is credited to the new pulse on confirmation (restart
  // at 1) or back to the old pulse when the excursion collapses (step 2).
  localparam bit FILT = 1'b1;
  assign nxt = tgt != mod_o && pend ? tgt : mod_o;
  assign pend_nxt = tgt != mod_o && !pend;
`else
  localparam bit FILT = 1'b0;
  assign nxt = tgt;
  assign pend_nxt = 1'b0;
`endif
  // The first evaluation after reset opens the first pulse and is not counted.
  assign step_nxt = !seen || pend_nxt ? 2'd0 : pend ? 2'd2 : 2'd1;
  assign add1 = {1'b0, pcnt} + (CNT_W + 1)'(1);
  assign adds = {2'b0, pcnt} + (CNT_W + 2)'(step);
  assign push = sl_upd && chg;
  assign xfer = pw.pw_valid && pw.pw_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run <= '0;
      scnt <= '0;
      env_o <= '0;
      env_upd <= 1'b0;
    end else begin
      env_upd <= win_end;
      if (samp_en) begin
        run <= win_end ? '0 : peak;
        scnt <= win_end ? '0 : scnt + SW'(1);
        if (win_end) env_o <= peak;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mod_o <= 1'b0;
      pend <= 1'b0;
      seen <= 1'b0;
      sl_upd <= 1'b0;
      chg <= 1'b0;
      step <= 2'd0;
    end else begin
      sl_upd <= env_upd;
      if (env_upd) begin
        mod_o <= nxt;
        pend <= pend_nxt;
        seen <= 1'b1;
        chg <= nxt != mod_o;
        step <= step_nxt;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt <= '0;
      pw.pw_data <= '0;
      pw.pw_level <= 1'b0;
      pw.pw_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (sl_upd) pcnt <= chg ? CNT_W'(FILT) : adds > {2'b0, CMAX} ? CMAX : adds[CNT_W-1:0];
      if (push && (!pw.pw_valid || xfer)) begin
        pw.pw_data <= add1[CNT_W] ? CMAX : add1[CNT_W-1:0];
        pw.pw_level <= !mod_o;
        pw.pw_valid <= 1'b1;
      end else begin
        if (xfer) pw.pw_valid <= 1'b0;
        if (push) ovf <= 1'b1;
      end
    end
endmodule

// File: tb/tb_nfc_demod.sv
// tb_nfc_demod: directed scoreboard bench for nfc_demod (default and CNT_W=4 instances)
module tb_nfc_demod;
  logic clk = 1'b0, rst = 1'b1, samp_en = 1'b0, rdy = 1'b1;
  logic signed [15:0] v_samp = '0;
  logic [14:0] thr_hi = 15'd6000, thr_lo = 15'd3000;
  logic [14:0] env_o, s_env;
  logic mod_o, ovf, s_mod, s_ovf;
  int checks = 0, fails = 0;
  typedef struct {
    logic level;
    int len;
  } rec_t;
  rec_t mq[$], sq[$];
  rec_t mr, sr;
  nfc_demod_if #(.CNT_W(16)) bus();
  nfc_demod_if #(.CNT_W(4)) sbus();
  assign bus.pw_ready = rdy;
  assign sbus.pw_ready = rdy;
  nfc_demod dut (
    .clk(clk), .rst(rst), .v_samp(v_samp), .samp_en(samp_en), .thr_hi(thr_hi),
    .thr_lo(thr_lo), .env_o(env_o), .mod_o(mod_o), .pw(bus), .ovf(ovf)
  );
  nfc_demod #(.CNT_W(4)) sat (
    .clk(clk), .rst(rst), .v_samp(v_samp), .samp_en(samp_en), .thr_hi(thr_hi),
    .thr_lo(thr_lo), .env_o(s_env), .mod_o(s_mod), .pw(sbus), .ovf(s_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.pw_valid && bus.pw_ready) begin
      chk("main_rec_expected", 32'(mq.size() != 0), 1);
      if (mq.size() != 0) begin
        mr = mq.pop_front();
        chk("main_level", bus.pw_level, mr.level);
        chk("main_len", bus.pw_data, mr.len);
      end
    end
    if (sbus.pw_valid && sbus.pw_ready) begin
      chk("sat_rec_expected", 32'(sq.size() != 0), 1);
      if (sq.size() != 0) begin
        sr = sq.pop_front();
        chk("sat_level", sbus.pw_level, sr.level);
        chk("sat_len", sbus.pw_data, sr.len);
      end
    end
  end
  task automatic samp(input logic [15:0] v);
    v_samp = v;
    samp_en = 1'b1;
    @(posedge clk);
    #1;
    samp_en = 1'b0;
  endtask
  task automatic win_raw(input int a, input int b);
    for (int i = 0; i < 16; i++) samp(16'(i % 2 ? b : a));
  endtask
  task automatic win(input int a, input int b);
    win_raw(a, b);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic expect_rec(input logic lv, input int ml, input int sl);
    mq.push_back('{lv, ml});
    sq.push_back('{lv, sl});
  endtask
  task automatic st(input string tag, input int e, input logic m);
    chk({tag, "_env"}, env_o, e);
    chk({tag, "_mod"}, mod_o, m);
    chk({tag, "_senv"}, s_env, e);
    chk({tag, "_smod"}, s_mod, m);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", env_o, 0);
    chk("rst_mod", mod_o, 0);
    chk("rst_valid", bus.pw_valid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    win(8000, -100);
    st("w1", 8000, 0);
    win(5000, 0);
    st("w2", 5000, 0);
    expect_rec(0, 2, 2);
    win(2500, 0);
    st("w3", 2500, 1);
    win(4000, 0);
    st("w4", 4000, 1);
    expect_rec(1, 2, 2);
    win(6500, 0);
    st("w5", 6500, 0);
    win(5000, -8000);
    st("env_alt", 8000, 0);
    win(100, -32768);
    st("env_sat", 32767, 0);
    rdy = 1'b0;
    expect_rec(0, 3, 3);
    win(2000, 0);
    st("sim_a", 2000, 1);
    chk("hold_valid", bus.pw_valid, 1);
    chk("hold_data", bus.pw_data, 3);
    expect_rec(1, 1, 1);
    win_raw(7000, 0);
    @(posedge clk);
    #1;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    chk("sim_valid", bus.pw_valid, 1);
    chk("sim_data", bus.pw_data, 1);
    chk("sim_level", bus.pw_level, 1);
    chk("sim_ovf", ovf, 0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("sim_drain", bus.pw_valid, 0);
    rdy = 1'b0;
    expect_rec(0, 1, 1);
    win(2000, 0);
    st("ovf_a", 2000, 1);
    win(7000, 0);
    st("ovf_b", 7000, 0);
    chk("ovf_data", bus.pw_data, 1);
    chk("ovf_level", bus.pw_level, 0);
    chk("ovf_valid", bus.pw_valid, 1);
    chk("ovf_set", ovf, 1);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_drain", bus.pw_valid, 0);
    chk("ovf_sticky", ovf, 1);
    for (int i = 0; i < 5; i++) samp(16'd9000);
    rst = 1'b1;
    #1;
    chk("mid_rst_env", env_o, 0);
    chk("mid_rst_mod", mod_o, 0);
    chk("mid_rst_valid", bus.pw_valid, 0);
    chk("mid_rst_data", bus.pw_data, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_sovf", s_ovf, 0);
    for (int i = 0; i < 4; i++) begin
      samp(16'd9000);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) samp(16'd7000);
    chk("post_rst_env0", env_o, 0);
    samp(16'd7000);
    chk("post_rst_env", env_o, 7000);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_mod", mod_o, 0);
    repeat (20) win(7000, 0);
    expect_rec(0, 21, 15);
    win(2000, 0);
    st("sat_chg", 2000, 1);
    expect_rec(1, 1, 1);
    win(7000, 0);
    st("after_sat", 7000, 0);
    thr_lo = 15'd7000;
    thr_hi = 15'd6000;
    expect_rec(0, 1, 1);
    win(6500, 0);
    st("both_true", 6500, 1);
    thr_lo = 15'd3000;
    thr_hi = 15'd6000;
    win(6000, 0);
    st("eq_hold", 6000, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("main_q_empty", mq.size(), 0);
    chk("sat_q_empty", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/nfc_demod.md
Name: nfc_demod

Overview:
- Digital receive-side demodulator for the NFC link; sits on the real-valued coil output of the `nfc` analog model, converted to a fixed-point code.
- Recovers the load-modulation envelope, slices it with hysteresis into a modulation level, and emits measured pulse durations (level + length) over a valid/ready interface.
- Downstream bit decoders consume the pulse records.

Parameters:
- WIDTH, 16, signed sample width of v_samp; 100 V full-scale maps to 2^(WIDTH-1)-1.
- WIN, 16, samples per envelope window, range 2..256.
- CNT_W, 16, width of the pulse-length counter, in windows.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- v_samp  in  WIDTH  signed sample of coil voltage
- samp_en  in  1  v_samp valid this cycle
- thr_hi  in  WIDTH-1  unsigned release threshold; env above it gives mod_o=0
- thr_lo  in  WIDTH-1  unsigned assert threshold; env below it gives mod_o=1
- env_o  out  WIDTH-1  last completed window peak magnitude
- mod_o  out  1  sliced modulation level; 1 = carrier loaded/attenuated
- pw_data  out  CNT_W  length of completed pulse, in windows
- pw_level  out  1  mod_o level during that pulse
- pw_valid  out  1  pulse record available
- pw_ready  in  1  consumer accepts record
- ovf  out  1  sticky: record dropped

Behaviour:
- Reset values: all outputs 0. Internal state also resets to 0: running max, sample count, pulse count, stage flags.
- Stage 1, magnitude and peak:
  - On samp_en, mag = |v_samp|; the most-negative code saturates to 2^(WIDTH-1)-1.
  - Running max updates to max(running, mag).
  - Sample count increments on samp_en. When it reaches WIN-1 with samp_en, the window ends (win_end): env_o takes the final max (including the current sample) next cycle. The running max and count both clear to 0.
  - Cycles without samp_en change nothing in this stage.
- Stage 2, slicer: evaluated one cycle after env_o updates.
  - env_o < thr_lo gives mod_o = 1.
  - env_o > thr_hi gives mod_o = 0.
  - Otherwise mod_o holds.
  - If thr_lo > thr_hi and both conditions are true, mod_o = 1 (assert wins).
- Stage 3, pulse measure:
  - On each slicer evaluation with no level change, the pulse count increments, saturating at 2^CNT_W-1.
  - On a level change, the record {previous level, count+1 saturated} is pushed and the count resets to 0.
  - Push to visible pw_valid is 1 cycle.
- Latency: win_end at cycle k gives env_o at k+1, mod_o at k+2, pw_valid at k+3.
- Output handshake, single-entry buffer:
  - Transfer when pw_valid && pw_ready; pw_valid drops next cycle unless a push arrives in the same cycle.
  - pw_data and pw_level are stable while pw_valid && !pw_ready.
  - Push while the buffer is full and not transferring: the new record is dropped, the buffer is unchanged, and ovf is set to 1.
  - Push in the same cycle as a transfer: the new record loads and pw_valid stays 1.
  - ovf clears only on rst.
- Reset mid-window or mid-pulse discards partial state; the first record after reset measures from the first slicer evaluation.
- Threshold changes take effect on the next slicer evaluation; no retiming.

Optional Feature:
- Macro NFC_DEMOD_GLITCH_FILT_EN.
- Defined:
  - The slicer changes mod_o only after the new condition holds on 2 consecutive slicer evaluations.
  - A single-window excursion produces no mod_o change and no record.
  - mod_o latency grows by one window.
  - Pulse length counts from the confirmed transition; the first window of the new level is credited to the new pulse.
- Undefined: behaviour as in Behaviour (single-evaluation response).

Test Plan:
- Reset/idle: rst asserted mid-window with samp_en toggling -> all outputs 0 on the same edge; env_o is first nonzero only after WIN samples after release.
- Envelope: WIN=16, samples alternating +5000/-8000 for one window -> env_o=8000. A sample of -32768 -> env_o=32767, no wrap.
- Hysteresis (thr_lo=3000, thr_hi=6000): env sequence 8000, 5000, 2500, 4000, 6500 -> mod_o sequence 0, 0, 1, 1, 0. Records are {0,2} then {1,2}.
- Handshake/overflow: pw_ready=0, two level changes -> first record held stable, second dropped, ovf=1. Then pw_ready=1 -> first record transfers, pw_valid falls.
- Simultaneous: push on the same cycle as a transfer -> new record visible next cycle, pw_valid continuously 1, ovf stays 0.
- Saturation/filter: CNT_W=4, 20 windows at constant level then a change -> pw_data=15. With NFC_DEMOD_GLITCH_FILT_EN, a one-window dip below thr_lo -> no mod_o change and no record.
